// File: rtl/sig_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | sig_pkg : shared types and sizes for the multiplier sweep ctrl  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package sig_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DRIVE = 3'd1,
      WAIT  = 3'd2,
      CHECK = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam int SIG_W     = 4;
   localparam int SIG_IDX_W = 2 * SIG_W;
   localparam int SIG_N     = 1 << SIG_IDX_W;
   localparam int SIG_CNT_W = SIG_IDX_W + 1;
   localparam int SIG_LAT_W = 4;

endpackage : sig_pkg
`default_nettype wire

// File: rtl/sig_sweep_ctrl_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | sig_sweep_ctrl_if : controller <-> datapath/status bundle       |
// | Optional SIG_ERRLOG_EN adds first-failure capture signals.      |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
interface sig_sweep_ctrl_if #(
   parameter int W = sig_pkg::SIG_W
);
   logic             iSTART;
   logic [W-1:0]     oX1;
   logic [W-1:0]     oX2;
   logic [2*W-1:0]   iSY;
   logic [2*W-1:0]   iUY;
   logic             oBUSY;
   logic             oDONE;
   logic             oPASS;
   logic [2*W:0]     oERR_CNT;
   logic             oSERR;
   logic             oUERR;
`ifdef SIG_ERRLOG_EN
   logic             oFAIL_VLD;
   logic [W-1:0]     oFAIL_X1;
   logic [W-1:0]     oFAIL_X2;

   modport master (
      input  iSTART, iSY, iUY,
      output oX1, oX2, oBUSY, oDONE, oPASS, oERR_CNT, oSERR, oUERR,
             oFAIL_VLD, oFAIL_X1, oFAIL_X2
   );
   modport slave (
      output iSTART, iSY, iUY,
      input  oX1, oX2, oBUSY, oDONE, oPASS, oERR_CNT, oSERR, oUERR,
             oFAIL_VLD, oFAIL_X1, oFAIL_X2
   );
`else
   modport master (
      input  iSTART, iSY, iUY,
      output oX1, oX2, oBUSY, oDONE, oPASS, oERR_CNT, oSERR, oUERR
   );
   modport slave (
      output iSTART, iSY, iUY,
      input  oX1, oX2, oBUSY, oDONE, oPASS, oERR_CNT, oSERR, oUERR
   );
`endif
endinterface : sig_sweep_ctrl_if
`default_nettype wire

// File: rtl/sig_ref_model.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | sig_ref_model : exact signed and unsigned W x W products        |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module sig_ref_model
   import sig_pkg::*;
#(
   parameter int W = SIG_W
) (
   input  logic [W-1:0]   x1_i,
   input  logic [W-1:0]   x2_i,
   output logic [2*W-1:0] ref_s_o,
   output logic [2*W-1:0] ref_u_o
);
   // Operands are widened to 2W first so the product cannot overflow
   assign ref_s_o = $signed({{W{x2_i[W-1]}}, x2_i}) * $signed({{W{x1_i[W-1]}}, x1_i});
   assign ref_u_o = {{W{1'b0}}, x2_i} * {{W{1'b0}}, x1_i};

endmodule : sig_ref_model
`default_nettype wire

// File: rtl/sig_sweep_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | sig_sweep_ctrl : exhaustive self-test sequencer for the         |
// | signed/unsigned multiplier pair. Optional macro: SIG_ERRLOG_EN. |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module sig_sweep_ctrl
   import sig_pkg::*;
#(
   parameter int W   = SIG_W,
   parameter int LAT = 0
) (
   input  logic             iCLK,
   input  logic             iRST_N,
   sig_sweep_ctrl_if.master bus
);
   localparam logic [SIG_LAT_W-1:0] LAT_INIT = (LAT > 0) ? SIG_LAT_W'(LAT - 1) : '0;

   state_t              state_q, state_d;
   logic [2*W-1:0]      idx_q, idx_d;
   logic [SIG_LAT_W-1:0] wcnt_q, wcnt_d;
   logic [W-1:0]        x1_q, x1_d;
   logic [W-1:0]        x2_q, x2_d;
   logic [2*W:0]        err_q, err_d;
   logic                serr_q, serr_d;
   logic                uerr_q, uerr_d;
   logic                pass_q, pass_d;
   logic                busy, done;
   logic [2*W-1:0]      ref_s, ref_u;
   logic                mis_s, mis_u;
`ifdef SIG_ERRLOG_EN
   logic                fvld_q, fvld_d;
   logic [W-1:0]        fx1_q, fx1_d;
   logic [W-1:0]        fx2_q, fx2_d;
`endif

   sig_ref_model #(.W(W)) u_ref (
      .x1_i    (x1_q),
      .x2_i    (x2_q),
      .ref_s_o (ref_s),
      .ref_u_o (ref_u)
   );

   assign mis_s = (bus.iSY != ref_s);
   assign mis_u = (bus.iUY != ref_u);

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q <= IDLE;
         idx_q   <= '0;
         wcnt_q  <= '0;
         x1_q    <= '0;
         x2_q    <= '0;
         err_q   <= '0;
         serr_q  <= 1'b0;
         uerr_q  <= 1'b0;
         pass_q  <= 1'b0;
`ifdef SIG_ERRLOG_EN
         fvld_q  <= 1'b0;
         fx1_q   <= '0;
         fx2_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         wcnt_q  <= wcnt_d;
         x1_q    <= x1_d;
         x2_q    <= x2_d;
         err_q   <= err_d;
         serr_q  <= serr_d;
         uerr_q  <= uerr_d;
         pass_q  <= pass_d;
`ifdef SIG_ERRLOG_EN
         fvld_q  <= fvld_d;
         fx1_q   <= fx1_d;
         fx2_q   <= fx2_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      wcnt_d  = wcnt_q;
      x1_d    = x1_q;
      x2_d    = x2_q;
      err_d   = err_q;
      serr_d  = serr_q;
      uerr_d  = uerr_q;
      pass_d  = pass_q;
      busy    = 1'b0;
      done    = 1'b0;
`ifdef SIG_ERRLOG_EN
      fvld_d  = fvld_q;
      fx1_d   = fx1_q;
      fx2_d   = fx2_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.iSTART) begin
               state_d = DRIVE;
               idx_d   = '0;
               err_d   = '0;
               serr_d  = 1'b0;
               uerr_d  = 1'b0;
               pass_d  = 1'b0;
`ifdef SIG_ERRLOG_EN
               fvld_d  = 1'b0;
               fx1_d   = '0;
               fx2_d   = '0;
`endif
            end
         end
         DRIVE: begin
            busy = 1'b1;
            x1_d = idx_q[W-1:0];
            x2_d = idx_q[2*W-1:W];
            if (LAT > 0) begin
               state_d = WAIT;
               wcnt_d  = LAT_INIT;
            end else begin
               state_d = CHECK;
            end
         end
         WAIT: begin
            busy = 1'b1;
            if (wcnt_q == '0) state_d = CHECK;
            else              wcnt_d  = wcnt_q - 1'b1;
         end
         CHECK: begin
            busy = 1'b1;
            // One count per vector even when both products are wrong
            if (mis_s || mis_u) begin
               err_d = err_q + 1'b1;
`ifdef SIG_ERRLOG_EN
               if (!fvld_q) begin
                  fvld_d = 1'b1;
                  fx1_d  = x1_q;
                  fx2_d  = x2_q;
               end
`endif
            end
            if (mis_s) serr_d = 1'b1;
            if (mis_u) uerr_d = 1'b1;
            if (idx_q == '1) begin
               state_d = DONE;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = DRIVE;
            end
         end
         DONE: begin
            done    = 1'b1;
            pass_d  = (err_q == '0);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.oX1      = x1_q;
   assign bus.oX2      = x2_q;
   assign bus.oBUSY    = busy;
   assign bus.oDONE    = done;
   assign bus.oPASS    = pass_q;
   assign bus.oERR_CNT = err_q;
   assign bus.oSERR    = serr_q;
   assign bus.oUERR    = uerr_q;
`ifdef SIG_ERRLOG_EN
   assign bus.oFAIL_VLD = fvld_q;
   assign bus.oFAIL_X1  = fx1_q;
   assign bus.oFAIL_X2  = fx2_q;
`endif

endmodule : sig_sweep_ctrl
`default_nettype wire

// File: tb/tb_sig_sweep_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_sig_sweep_ctrl : directed bench, LAT=0 and LAT=3 instances   |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tb_sig_sweep_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start0 = 1'b0;
   logic start3 = 1'b0;
   int   fault0 = 0;
   bit   sel = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   sig_sweep_ctrl_if #(.W(4)) b0 ();
   sig_sweep_ctrl_if #(.W(4)) b3 ();

   sig_sweep_ctrl #(.W(4), .LAT(0)) u0 (.iCLK(clk), .iRST_N(rst_n), .bus(b0.master));
   sig_sweep_ctrl #(.W(4), .LAT(3)) u3 (.iCLK(clk), .iRST_N(rst_n), .bus(b3.master));

   logic [3:0] rx1, rx2;
   logic [7:0] rs, ru;
   sig_ref_model #(.W(4)) u_ref (.x1_i(rx1), .x2_i(rx2), .ref_s_o(rs), .ref_u_o(ru));

   // Behavioural multiplier datapath, with fault injection on instance 0
   logic [7:0] sy0, uy0;
   always_comb begin
      sy0 = 8'(int'($signed(b0.oX2)) * int'($signed(b0.oX1)));
      uy0 = 8'(int'(b0.oX2) * int'(b0.oX1));
      if (fault0 == 1 && b0.oX1 == 4'd3 && b0.oX2 == 4'd5) uy0 = 8'h00;
      if (fault0 == 2 && b0.oX1 == 4'hF && b0.oX2 == 4'h1) sy0 = 8'h7E;
   end
   assign b0.iSY    = sy0;
   assign b0.iUY    = uy0;
   assign b0.iSTART = start0;
   assign b3.iSY    = 8'(int'($signed(b3.oX2)) * int'($signed(b3.oX1)));
   assign b3.iUY    = 8'(int'(b3.oX2) * int'(b3.oX1));
   assign b3.iSTART = start3;

   logic       done_m, busy_m;
   logic [7:0] idx_m;
   always_comb begin
      done_m = sel ? b3.oDONE : b0.oDONE;
      busy_m = sel ? b3.oBUSY : b0.oBUSY;
      idx_m  = sel ? {b3.oX2, b3.oX1} : {b0.oX2, b0.oX1};
   end

   // Runs one sweep; edge 1 is the edge sampling iSTART
   task automatic sweep(input bit s, input int repulse_at, input int rst_at,
                        output int done_edge, output int pulses, output int busy_gaps,
                        output bit rst_ok);
      int e;
      bit rep, rstd;
      e = 0; done_edge = -1; pulses = 0; busy_gaps = 0; rst_ok = 1'b0; rep = 0; rstd = 0;
      sel = s;
      @(negedge clk);
      if (s) start3 = 1'b1; else start0 = 1'b1;
      while (e < 1400) begin
         @(posedge clk);
         e++;
         @(negedge clk);
         start0 = 1'b0;
         start3 = 1'b0;
         if (!rst_n) rst_n = 1'b1;
         if (done_m) begin
            pulses++;
            if (done_edge < 0) done_edge = e;
         end else if (done_edge < 0 && !rstd && !busy_m) begin
            busy_gaps++;
         end
         if (repulse_at >= 0 && !rep && done_edge < 0 && idx_m == 8'(repulse_at)) begin
            rep = 1;
            start0 = 1'b1;
         end
         if (rst_at >= 0 && !rstd && busy_m && idx_m == 8'(rst_at)) begin
            rstd = 1;
            rst_n = 1'b0;
            #1;
            rst_ok = (b0.oX1 == 4'd0 && b0.oX2 == 4'd0 && !b0.oBUSY && !b0.oDONE &&
                      !b0.oPASS && b0.oERR_CNT == 9'd0 && !b0.oSERR && !b0.oUERR);
         end
         if (done_edge >= 0 && e >= done_edge + 10) break;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_chk++; if ({b0.oX2, b0.oX1} !== 8'h00) begin n_fail++; $display("FAIL reset_x got=%h exp=00", {b0.oX2, b0.oX1}); end
      n_chk++; if ({b0.oBUSY, b0.oDONE, b0.oPASS} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {b0.oBUSY, b0.oDONE, b0.oPASS}); end
      n_chk++; if (b0.oERR_CNT !== 9'd0) begin n_fail++; $display("FAIL reset_err got=%0d exp=0", b0.oERR_CNT); end
      n_chk++; if ({b0.oSERR, b0.oUERR} !== 2'b00) begin n_fail++; $display("FAIL reset_sticky got=%b exp=00", {b0.oSERR, b0.oUERR}); end
      n_chk++; if ({b3.oBUSY, b3.oDONE, b3.oPASS} !== 3'b000) begin n_fail++; $display("FAIL reset_flags3 got=%b exp=000", {b3.oBUSY, b3.oDONE, b3.oPASS}); end
`ifdef SIG_ERRLOG_EN
      n_chk++; if (b0.oFAIL_VLD !== 1'b0) begin n_fail++; $display("FAIL reset_fvld got=%b exp=0", b0.oFAIL_VLD); end
`endif
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_lat0;
      int de, np, bg; bit ro;
      fault0 = 0;
      sweep(1'b0, -1, -1, de, np, bg, ro);
      n_chk++; if (de !== 513) begin n_fail++; $display("FAIL lat0_done_edge got=%0d exp=513", de); end
      n_chk++; if (np !== 1) begin n_fail++; $display("FAIL lat0_pulses got=%0d exp=1", np); end
      n_chk++; if (b0.oERR_CNT !== 9'd0 || b0.oPASS !== 1'b1) begin n_fail++; $display("FAIL lat0_result err=%0d pass=%b exp err=0 pass=1", b0.oERR_CNT, b0.oPASS); end
      n_chk++; if ({b0.oSERR, b0.oUERR} !== 2'b00) begin n_fail++; $display("FAIL lat0_sticky got=%b exp=00", {b0.oSERR, b0.oUERR}); end
      n_chk++; if ({b0.oX2, b0.oX1} !== 8'hFF) begin n_fail++; $display("FAIL lat0_hold_x got=%h exp=FF", {b0.oX2, b0.oX1}); end
   endtask

   task automatic test_lat3;
      int de, np, bg; bit ro;
      sweep(1'b1, -1, -1, de, np, bg, ro);
      n_chk++; if (de !== 1281) begin n_fail++; $display("FAIL lat3_done_edge got=%0d exp=1281", de); end
      n_chk++; if (bg !== 0) begin n_fail++; $display("FAIL lat3_busy_gaps got=%0d exp=0", bg); end
      n_chk++; if (b3.oERR_CNT !== 9'd0 || b3.oPASS !== 1'b1) begin n_fail++; $display("FAIL lat3_result err=%0d pass=%b exp err=0 pass=1", b3.oERR_CNT, b3.oPASS); end
   endtask

   task automatic test_ufault;
      int de, np, bg; bit ro;
      fault0 = 1;
      sweep(1'b0, -1, -1, de, np, bg, ro);
      n_chk++; if (b0.oERR_CNT !== 9'd1) begin n_fail++; $display("FAIL ufault_err got=%0d exp=1", b0.oERR_CNT); end
      n_chk++; if ({b0.oSERR, b0.oUERR} !== 2'b01) begin n_fail++; $display("FAIL ufault_sticky got=%b exp=01", {b0.oSERR, b0.oUERR}); end
      n_chk++; if (b0.oPASS !== 1'b0) begin n_fail++; $display("FAIL ufault_pass got=%b exp=0", b0.oPASS); end
`ifdef SIG_ERRLOG_EN
      n_chk++; if ({b0.oFAIL_VLD, b0.oFAIL_X2, b0.oFAIL_X1} !== 9'h153) begin n_fail++; $display("FAIL ufault_log got=%h exp=153", {b0.oFAIL_VLD, b0.oFAIL_X2, b0.oFAIL_X1}); end
`endif
      fault0 = 0;
   endtask

   task automatic test_corners;
      int de, np, bg; bit ro;
      rx1 = 4'h8; rx2 = 4'h8; #1;
      n_chk++; if ({rs, ru} !== 16'h4040) begin n_fail++; $display("FAIL corner_88 got=%h exp=4040", {rs, ru}); end
      rx1 = 4'hF; rx2 = 4'h1; #1;
      n_chk++; if ({rs, ru} !== 16'hFF0F) begin n_fail++; $display("FAIL corner_F1 got=%h exp=FF0F", {rs, ru}); end
      rx1 = 4'h7; rx2 = 4'h9; #1;
      n_chk++; if ({rs, ru} !== 16'hCF3F) begin n_fail++; $display("FAIL corner_79 got=%h exp=CF3F", {rs, ru}); end
      fault0 = 2;
      sweep(1'b0, -1, -1, de, np, bg, ro);
      n_chk++; if ({b0.oSERR, b0.oUERR} !== 2'b10) begin n_fail++; $display("FAIL sfault_sticky got=%b exp=10", {b0.oSERR, b0.oUERR}); end
      n_chk++; if (b0.oERR_CNT !== 9'd1 || b0.oPASS !== 1'b0) begin n_fail++; $display("FAIL sfault_result err=%0d pass=%b exp err=1 pass=0", b0.oERR_CNT, b0.oPASS); end
      fault0 = 0;
   endtask

   task automatic test_restart_ignored;
      int de, np, bg; bit ro;
      sweep(1'b0, 40, -1, de, np, bg, ro);
      n_chk++; if (de !== 513) begin n_fail++; $display("FAIL repulse_done_edge got=%0d exp=513", de); end
      n_chk++; if (np !== 1) begin n_fail++; $display("FAIL repulse_pulses got=%0d exp=1", np); end
      n_chk++; if (b0.oPASS !== 1'b1) begin n_fail++; $display("FAIL repulse_pass got=%b exp=1", b0.oPASS); end
   endtask

   task automatic test_reset_abort;
      int de, np, bg; bit ro;
      sweep(1'b0, -1, 100, de, np, bg, ro);
      n_chk++; if (ro !== 1'b1) begin n_fail++; $display("FAIL abort_outputs got=%b exp=1", ro); end
      n_chk++; if (np !== 0) begin n_fail++; $display("FAIL abort_pulses got=%0d exp=0", np); end
      sweep(1'b0, -1, -1, de, np, bg, ro);
      n_chk++; if (de !== 513) begin n_fail++; $display("FAIL abort_restart_edge got=%0d exp=513", de); end
      n_chk++; if (b0.oPASS !== 1'b1) begin n_fail++; $display("FAIL abort_restart_pass got=%b exp=1", b0.oPASS); end
   endtask

   task automatic test_back_to_back;
      int n;
      bit seen;
      seen = 0;
      @(negedge clk);
      start0 = 1'b1;
      for (n = 0; n < 1400 && !seen; n++) begin
         @(negedge clk);
         seen = b0.oDONE;
      end
      n_chk++; if (!seen) begin n_fail++; $display("FAIL b2b_done got=0 exp=1"); end
      repeat (2) @(negedge clk);
      n_chk++; if (b0.oBUSY !== 1'b1 || b0.oPASS !== 1'b0) begin n_fail++; $display("FAIL b2b_restart busy=%b pass=%b exp busy=1 pass=0", b0.oBUSY, b0.oPASS); end
      start0 = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_lat0();
      test_lat3();
      test_ufault();
      test_corners();
      test_restart_ignored();
      test_reset_abort();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule : tb_sig_sweep_ctrl
`default_nettype wire
